// File: rtl/ex_mem_pkg.sv
// Shared types and widths for the EX/MEM pipeline register and its NoC transmit port.
package ex_mem_pkg;

  localparam int NOC_DEST_W = 2;
  localparam int NOC_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } noc_tx_state_t;

  typedef struct packed {
    logic [NOC_DEST_W-1:0] dest;
    logic [NOC_DATA_W-1:0] data;
  } noc_pkt_t;

endpackage

// File: rtl/ex_mem_stage_noc_tx.sv
// NoC transmit port: IDLE/SEND FSM, held packet register, accepted-packet counter and
// pipeline stall generation. The FSM state is exported on state_o for observation.
module noc_tx_port
  import ex_mem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_i,
  input  noc_pkt_t             pkt_i,
  input  logic                 ready_i,
  output noc_tx_state_t        state_o,
  output noc_pkt_t             pkt_o,
  output logic                 stall_o,
  output logic [CNT_W-1:0]     cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  noc_tx_state_t    state_q;
  noc_pkt_t         pkt_q;
  logic [CNT_W-1:0] cnt_q;

  // Handshake: a packet transfers on any rising edge where valid (state SEND) and ready
  // are both high. The payload is held unchanged while valid is high and ready is low.
  // Stall depends on ready only combinationally; valid never depends on ready.
  assign stall_o = (state_q == SEND) && !ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if ((state_q == SEND) && ready_i) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (!stall_o) begin
        if (req_i) begin
          pkt_q   <= pkt_i;
          state_q <= SEND;
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign state_o = state_q;
  assign pkt_o   = pkt_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with bubble insertion while the NoC transmit port stalls.
// Optional EX_MEM_FLUSH_EN adds flush_E, which turns the EX instruction into a bubble.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegW_enable_E,
  input  logic                  Mem_Write_E,
  input  logic                  Mem_Read_E,
  input  logic                  Result_src_E,
  input  logic [31:0]           alu_result_E,
  input  logic [31:0]           write_data_E,
  input  logic [4:0]            Radd_E,
  input  logic [NOC_DEST_W-1:0] dest_add_E,
  input  logic                  proc_valid_E,
`ifdef EX_MEM_FLUSH_EN
  input  logic                  flush_E,
`endif
  output logic                  RegW_enable_M,
  output logic                  Mem_Write_M,
  output logic                  Mem_Read_M,
  output logic                  Result_src_M,
  output logic [31:0]           alu_result_M,
  output logic [31:0]           write_data_M,
  output logic [4:0]            Radd_M,
  output logic                  noc_valid_o,
  output logic [NOC_DEST_W-1:0] noc_dest_o,
  output logic [NOC_DATA_W-1:0] noc_data_o,
  input  logic                  noc_ready_i,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      noc_pkt_cnt_o
);

  logic          kill;
  noc_tx_state_t tx_state;
  noc_pkt_t      tx_pkt;

  logic          regw_q, memw_q, memr_q, rsrc_q;
  logic [31:0]   alu_q, wdata_q;
  logic [4:0]    radd_q;

`ifdef EX_MEM_FLUSH_EN
  assign kill = flush_E;
`else
  assign kill = 1'b0;
`endif

  noc_tx_port #(.CNT_W(CNT_W)) u_noc_tx (
    .clk     (clk),
    .rst     (rst),
    .req_i   (proc_valid_E && !kill),
    .pkt_i   ('{dest: dest_add_E, data: alu_result_E}),
    .ready_i (noc_ready_i),
    .state_o (tx_state),
    .pkt_o   (tx_pkt),
    .stall_o (stall_o),
    .cnt_o   (noc_pkt_cnt_o)
  );

  // A bubble clears only the control bits; the data fields keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regw_q  <= 1'b0;
      memw_q  <= 1'b0;
      memr_q  <= 1'b0;
      rsrc_q  <= 1'b0;
      alu_q   <= '0;
      wdata_q <= '0;
      radd_q  <= '0;
    end else if (stall_o || kill) begin
      regw_q  <= 1'b0;
      memw_q  <= 1'b0;
      memr_q  <= 1'b0;
      rsrc_q  <= 1'b0;
    end else begin
      regw_q  <= RegW_enable_E;
      memw_q  <= Mem_Write_E;
      memr_q  <= Mem_Read_E;
      rsrc_q  <= Result_src_E;
      alu_q   <= alu_result_E;
      wdata_q <= write_data_E;
      radd_q  <= Radd_E;
    end
  end

  assign RegW_enable_M = regw_q;
  assign Mem_Write_M   = memw_q;
  assign Mem_Read_M    = memr_q;
  assign Result_src_M  = rsrc_q;
  assign alu_result_M  = alu_q;
  assign write_data_M  = wdata_q;
  assign Radd_M        = radd_q;

  assign noc_valid_o = (tx_state == SEND);
  assign noc_dest_o  = tx_pkt.dest;
  assign noc_data_o  = tx_pkt.data;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed test-plan sequences plus random traffic, checked by a
// cycle monitor against a transaction-level model (expected MEM queue, pending packet queue).
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic RegW_enable_E, Mem_Write_E, Mem_Read_E, Result_src_E;
  logic [31:0] alu_result_E, write_data_E;
  logic [4:0]  Radd_E;
  logic [1:0]  dest_add_E;
  logic        proc_valid_E;
  logic        flush_E;
  logic RegW_enable_M, Mem_Write_M, Mem_Read_M, Result_src_M;
  logic [31:0] alu_result_M, write_data_M;
  logic [4:0]  Radd_M;
  logic        noc_valid_o;
  logic [1:0]  noc_dest_o;
  logic [31:0] noc_data_o;
  logic        noc_ready_i;
  logic        stall_o;
  logic [CNT_W-1:0] noc_pkt_cnt_o;

  ex_mem_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegW_enable_E(RegW_enable_E), .Mem_Write_E(Mem_Write_E), .Mem_Read_E(Mem_Read_E),
    .Result_src_E(Result_src_E), .alu_result_E(alu_result_E), .write_data_E(write_data_E),
    .Radd_E(Radd_E), .dest_add_E(dest_add_E), .proc_valid_E(proc_valid_E),
`ifdef EX_MEM_FLUSH_EN
    .flush_E(flush_E),
`endif
    .RegW_enable_M(RegW_enable_M), .Mem_Write_M(Mem_Write_M), .Mem_Read_M(Mem_Read_M),
    .Result_src_M(Result_src_M), .alu_result_M(alu_result_M), .write_data_M(write_data_M),
    .Radd_M(Radd_M), .noc_valid_o(noc_valid_o), .noc_dest_o(noc_dest_o),
    .noc_data_o(noc_data_o), .noc_ready_i(noc_ready_i), .stall_o(stall_o),
    .noc_pkt_cnt_o(noc_pkt_cnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mw, mr, rs;
    logic [31:0] alu, wd;
    logic [4:0]  radd;
    logic [1:0]  dest;
    logic        pv, fl;
  } ex_t;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  radd;
  } mem_t;

  // ---------------- scoreboard state ----------------
  mem_t        exp_q[$];
  logic [33:0] pkt_q[$];
  mem_t        last_mem;
  int unsigned m_cnt;
  int          checks;
  int          failures;
  bit          chk_en;

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      mem_t got;
      mem_t e;
      got = {RegW_enable_M, Mem_Write_M, Mem_Read_M, Result_src_M,
             alu_result_M, write_data_M, Radd_M};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_q_empty actual=%0h expected=none", got);
      end else begin
        e = exp_q.pop_front();
        chk("mem_stage", got, e);
      end
      chk("noc_valid", noc_valid_o, pkt_q.size() != 0);
      if (pkt_q.size() != 0) chk("noc_pkt", {noc_dest_o, noc_data_o}, pkt_q[0]);
      chk("pkt_cnt", noc_pkt_cnt_o, m_cnt[CNT_W-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic ex_t mk(input logic pv, input logic [1:0] dest, input logic [31:0] alu,
                             input logic [4:0] radd, input logic rw);
    ex_t e;
    e.rw = rw; e.mw = 1'b0; e.mr = 1'b0; e.rs = 1'b0;
    e.alu = alu; e.wd = 32'h0; e.radd = radd; e.dest = dest;
    e.pv = pv; e.fl = 1'b0;
    return e;
  endfunction

  function automatic ex_t rand_ex();
    ex_t e;
    e.rw = 1'($urandom); e.mw = 1'($urandom); e.mr = 1'($urandom); e.rs = 1'($urandom);
    e.alu = $urandom; e.wd = $urandom; e.radd = 5'($urandom); e.dest = 2'($urandom);
    e.pv = ($urandom_range(0, 1) == 1);
`ifdef EX_MEM_FLUSH_EN
    e.fl = ($urandom_range(0, 7) == 0);
`else
    e.fl = 1'b0;
`endif
    return e;
  endfunction

  // One cycle: drive EX + ready, predict stall, queue the expected MEM contents for the edge.
  task automatic step(input ex_t ex, input logic rdy, output bit adv);
    bit   st;
    mem_t m;
    @(negedge clk);
    RegW_enable_E = ex.rw; Mem_Write_E = ex.mw; Mem_Read_E = ex.mr; Result_src_E = ex.rs;
    alu_result_E = ex.alu; write_data_E = ex.wd; Radd_E = ex.radd; dest_add_E = ex.dest;
    proc_valid_E = ex.pv; flush_E = ex.fl; noc_ready_i = rdy;
    #1;
    st = (pkt_q.size() != 0) && !rdy;
    chk("stall", stall_o, st);
    if (st || ex.fl) m = '{4'b0, last_mem.alu, last_mem.wd, last_mem.radd};
    else             m = '{{ex.rw, ex.mw, ex.mr, ex.rs}, ex.alu, ex.wd, ex.radd};
    last_mem = m;
    exp_q.push_back(m);
    if (!st) begin
      if (pkt_q.size() != 0) begin
        void'(pkt_q.pop_front());
        m_cnt++;
      end
      if (ex.pv && !ex.fl) pkt_q.push_back({ex.dest, ex.alu});
    end
    adv = !st;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    noc_ready_i = 1'b0;
    #2;
    chk("pre_rst_valid", noc_valid_o, pkt_q.size() != 0);
    rst = 1'b1;
    #1;
    chk("rst_mem", {RegW_enable_M, Mem_Write_M, Mem_Read_M, Result_src_M,
                    alu_result_M, write_data_M, Radd_M}, '0);
    chk("rst_noc", {noc_valid_o, noc_dest_o, noc_data_o, stall_o}, '0);
    chk("rst_cnt", noc_pkt_cnt_o, '0);
    exp_q.delete();
    pkt_q.delete();
    m_cnt = 0;
    last_mem = '0;
    RegW_enable_E = 0; Mem_Write_E = 0; Mem_Read_E = 0; Result_src_E = 0;
    alu_result_E = '0; write_data_E = '0; Radd_E = '0; dest_add_E = '0;
    proc_valid_E = 0; flush_E = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ex_t nop;
    ex_t cur;
    bit  adv;
    checks = 0; failures = 0; m_cnt = 0; last_mem = '0; chk_en = 1'b0;
    rst = 1'b1;
    RegW_enable_E = 0; Mem_Write_E = 0; Mem_Read_E = 0; Result_src_E = 0;
    alu_result_E = '0; write_data_E = '0; Radd_E = '0; dest_add_E = '0;
    proc_valid_E = 0; flush_E = 0; noc_ready_i = 0;
    nop = mk(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);

    do_reset();

    // Plain EX add reaches MEM one cycle later.
    step(mk(1'b0, 2'd0, 32'h10, 5'd5, 1'b1), 1'b1, adv);
    step(nop, 1'b1, adv);

    // Single send, receiver ready: no stall.
    step(mk(1'b1, 2'd2, 32'hCAFE, 5'd7, 1'b1), 1'b1, adv);
    step(nop, 1'b1, adv);
    step(nop, 1'b1, adv);

    // Send with ready low for three cycles; the following instruction is held upstream.
    step(mk(1'b1, 2'd2, 32'hCAFE, 5'd7, 1'b1), 1'b1, adv);
    cur = mk(1'b0, 2'd0, 32'h1234, 5'd9, 1'b1);
    repeat (3) step(cur, 1'b0, adv);
    step(cur, 1'b1, adv);
    step(nop, 1'b1, adv);

    // Back-to-back sends.
    step(mk(1'b1, 2'd1, 32'h1, 5'd1, 1'b0), 1'b1, adv);
    step(mk(1'b1, 2'd3, 32'h2, 5'd2, 1'b0), 1'b1, adv);
    step(nop, 1'b1, adv);
    step(nop, 1'b1, adv);

    // Counter wrap: five more packets on a 2-bit counter.
    for (int i = 0; i < 5; i++) step(mk(1'b1, 2'(i), 32'(i + 16), 5'(i), 1'b1), 1'b1, adv);
    step(nop, 1'b1, adv);
    step(nop, 1'b1, adv);

    // Reset while a packet is waiting on a low ready.
    step(mk(1'b1, 2'd3, 32'hBEEF, 5'd4, 1'b0), 1'b1, adv);
    do_reset();

`ifdef EX_MEM_FLUSH_EN
    cur = mk(1'b1, 2'd1, 32'h77, 5'd3, 1'b1);
    cur.fl = 1'b1;
    step(cur, 1'b1, adv);
    step(nop, 1'b1, adv);
`endif

    // Random traffic; a stalled instruction is re-presented until it advances.
    adv = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (adv) cur = rand_ex();
      step(cur, ($urandom_range(0, 3) != 0), adv);
      if (i == 200) do_reset();
      if (i == 200) adv = 1'b1;
    end
    step(nop, 1'b1, adv);
    step(nop, 1'b1, adv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
